// File: rtl/encoder_16x4_queue_pkg.sv
// ============================================================================
// encoder_16x4_queue_pkg : shared widths, presenter state type, popcount helper
// Revision: 1.0
// ============================================================================
`default_nettype none

package encoder_16x4_queue_pkg;

  localparam int REQ_W  = 16;
  localparam int CODE_W = 4;
  localparam int CNT_W  = 5;

  typedef enum logic {
    EMPTY   = 1'b0,
    PRESENT = 1'b1
  } state_t;

  function automatic logic [CNT_W-1:0] popcount(input logic [REQ_W-1:0] vec);
    logic [CNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < REQ_W; i++) begin
      cnt = cnt + {{(CNT_W-1){1'b0}}, vec[i]};
    end
    return cnt;
  endfunction

endpackage

`default_nettype wire

// File: rtl/prienc16.sv
// ============================================================================
// prienc16 : 16-bit lowest-set-bit finder (index 0 has highest priority)
// Revision: 1.0
// ============================================================================
`default_nettype none

module prienc16
  import encoder_16x4_queue_pkg::*;
(
  input  logic [REQ_W-1:0]  vec,
  output logic [CODE_W-1:0] idx,
  output logic              any
);

  // Scan downward so the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = REQ_W - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = CODE_W'(i);
        any = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/encoder_16x4_queue.sv
// ============================================================================
// encoder_16x4_queue : coalescing pending register feeding a valid/ready
//                      priority-encoded index output
// Revision: 1.0
// ============================================================================
`default_nettype none

module encoder_16x4_queue
  import encoder_16x4_queue_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [REQ_W-1:0]  req,
  input  logic              ready,
  output logic              valid,
  output logic [CODE_W-1:0] code,
  output logic [CNT_W-1:0]  pend_cnt,
  output logic              ovf
);

  state_t              state;
  state_t              state_next;
  logic [REQ_W-1:0]    pending;
  logic [REQ_W-1:0]    pending_next;
  logic [REQ_W-1:0]    load_mask;
  logic [CODE_W-1:0]   code_next;
  logic [CODE_W-1:0]   pe_idx;
  logic                pe_any;
  logic                load;
  logic                ovf_next;

  prienc16 u_prienc (
    .vec (pending),
    .idx (pe_idx),
    .any (pe_any)
  );

  assign load  = (state == EMPTY) || ready;
  assign valid = (state == PRESENT);

  always_comb begin
    state_next = state;
    code_next  = code;
    load_mask  = '0;
    if (load) begin
      if (pe_any) begin
        state_next = PRESENT;
        code_next  = pe_idx;
        load_mask  = {{(REQ_W-1){1'b0}}, 1'b1} << pe_idx;
      end else begin
        state_next = EMPTY;
      end
    end
    // The index being handed out is cleared before merging, so re-requesting
    // it (or the one already on code) is a fresh entry, not a lost one.
    pending_next = (pending & ~load_mask) | req;
    ovf_next     = |(req & pending & ~load_mask);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= EMPTY;
      pending  <= '0;
      code     <= '0;
      pend_cnt <= '0;
      ovf      <= 1'b0;
    end else begin
      state    <= state_next;
      pending  <= pending_next;
      code     <= code_next;
      pend_cnt <= popcount(pending_next);
      ovf      <= ovf_next;
    end
  end

endmodule

`default_nettype wire
